// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: multi-source interrupt controller for the OTTER_MCU.
// Syncs and edge-detects IRQ lines, latches them as pending, then picks one
// by fixed priority and runs the take/service/mret handshake with the CSR.
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   IRQ_IN       raw async interrupt lines, rising-edge sensitive
//   IRQ_EN       per-source enable
//   CSR_MSTATUS  global MIE
//   BOUNDARY     MCU at instruction boundary
//   CSR_MRET     MRET executing this cycle
//   INT_TAKEN    1-cycle take pulse
//   INT_ID       index of the source taken
//   IN_SERVICE   handler active
//   PENDING      latched pending bits
module otter_intr_ctrl #(
  parameter  int NUM_SRC     = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  input  logic [NUM_SRC-1:0] IRQ_EN,
  input  logic               CSR_MSTATUS,
  input  logic               BOUNDARY,
  input  logic               CSR_MRET,
  output logic               INT_TAKEN,
  output logic [ID_W-1:0]    INT_ID,
  output logic               IN_SERVICE,
  output logic [NUM_SRC-1:0] PENDING
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t state;

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] sync;
  logic [NUM_SRC-1:0] hist;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    winner;
  logic               take;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
      hist <= '0;
    end else begin
      sync_q[0] <= IRQ_IN;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
      hist <= sync;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~hist;
  assign elig = PENDING & IRQ_EN;
  assign take = (|elig) && CSR_MSTATUS && BOUNDARY;

  // Lowest set index wins: scan downward so the last hit is the lowest.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (elig[i])
        winner = ID_W'(i);
  end

  always_comb begin
    clr = '0;
    if (state == TAKE)
      clr[INT_ID] = 1'b1;
  end

  // Set after clear so a fresh edge on the source being taken survives.
  always_ff @(posedge CLK) begin
    if (RST)
      PENDING <= '0;
    else
      PENDING <= (PENDING & ~clr) | rise;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      INT_TAKEN  <= 1'b0;
      IN_SERVICE <= 1'b0;
      INT_ID     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            state      <= TAKE;
            INT_TAKEN  <= 1'b1;
            IN_SERVICE <= 1'b1;
            INT_ID     <= winner;
          end
        end
        TAKE: begin
          state     <= SERVICE;
          INT_TAKEN <= 1'b0;
        end
        SERVICE: begin
          if (CSR_MRET) begin
            state      <= IDLE;
            IN_SERVICE <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          INT_TAKEN  <= 1'b0;
          IN_SERVICE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// tb_otter_intr_ctrl: directed bench for otter_intr_ctrl.
// Cycle vectors for reset/latency, hand sequences for the rest.
module tb_otter_intr_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] IRQ_IN;
  logic [3:0] IRQ_EN;
  logic       CSR_MSTATUS;
  logic       BOUNDARY;
  logic       CSR_MRET;
  logic       INT_TAKEN;
  logic [1:0] INT_ID;
  logic       IN_SERVICE;
  logic [3:0] PENDING;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  otter_intr_ctrl #(
    .NUM_SRC    (4),
    .SYNC_STAGES(2)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IRQ_IN     (IRQ_IN),
    .IRQ_EN     (IRQ_EN),
    .CSR_MSTATUS(CSR_MSTATUS),
    .BOUNDARY   (BOUNDARY),
    .CSR_MRET   (CSR_MRET),
    .INT_TAKEN  (INT_TAKEN),
    .INT_ID     (INT_ID),
    .IN_SERVICE (IN_SERVICE),
    .PENDING    (PENDING)
  );

  typedef struct {
    logic       rst;
    logic [3:0] irq;
    logic [3:0] en;
    logic       mie;
    logic       bnd;
    logic       mret;
    logic       taken;
    logic [1:0] id;
    logic       svc;
    logic [3:0] pend;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic t, input logic [1:0] id,
                         input logic s, input logic [3:0] p);
    check({nm, ".taken"}, 32'(INT_TAKEN), 32'(t));
    check({nm, ".id"}, 32'(INT_ID), 32'(id));
    check({nm, ".svc"}, 32'(IN_SERVICE), 32'(s));
    check({nm, ".pend"}, 32'(PENDING), 32'(p));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    CSR_MRET = 1'b0;
    IRQ_IN = 4'h0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] i,
    input logic [3:0] e, input logic m, input logic b, input logic mr,
    input logic t, input logic [1:0] id, input logic s, input logic [3:0] p);
    vec_t v;
    v.rst = r; v.irq = i; v.en = e; v.mie = m; v.bnd = b; v.mret = mr;
    v.taken = t; v.id = id; v.svc = s; v.pend = p;
    return v;
  endfunction

  int takes;

  initial begin
    RST = 1'b1;
    IRQ_IN = 4'h0;
    IRQ_EN = 4'h0;
    CSR_MSTATUS = 1'b0;
    BOUNDARY = 1'b1;
    CSR_MRET = 1'b0;

    // reset with lines high, then release; then latency on source 2
    vecs[0]  = mk(1, 4'hF, 4'h0, 0, 1, 0, 0, 0, 0, 4'h0);
    vecs[1]  = mk(1, 4'hF, 4'h0, 0, 1, 0, 0, 0, 0, 4'h0);
    vecs[2]  = mk(0, 4'hF, 4'h0, 0, 1, 0, 0, 0, 0, 4'h0);
    vecs[3]  = mk(0, 4'hF, 4'h0, 0, 1, 0, 0, 0, 0, 4'h0);
    vecs[4]  = mk(0, 4'hF, 4'h0, 0, 1, 0, 0, 0, 0, 4'hF);
    vecs[5]  = mk(0, 4'hF, 4'h0, 0, 1, 0, 0, 0, 0, 4'hF);
    vecs[6]  = mk(1, 4'h0, 4'h4, 1, 1, 0, 0, 0, 0, 4'h0);
    vecs[7]  = mk(0, 4'h0, 4'h4, 1, 1, 0, 0, 0, 0, 4'h0);
    vecs[8]  = mk(0, 4'h4, 4'h4, 1, 1, 0, 0, 0, 0, 4'h0);
    vecs[9]  = mk(0, 4'h4, 4'h4, 1, 1, 0, 0, 0, 0, 4'h0);
    vecs[10] = mk(0, 4'h4, 4'h4, 1, 1, 0, 0, 0, 0, 4'h4);
    vecs[11] = mk(0, 4'h4, 4'h4, 1, 1, 0, 1, 2, 1, 4'h4);
    vecs[12] = mk(0, 4'h4, 4'h4, 1, 1, 0, 0, 2, 1, 4'h0);
    vecs[13] = mk(0, 4'h4, 4'h4, 1, 1, 0, 0, 2, 1, 4'h0);
    vecs[14] = mk(0, 4'h4, 4'h4, 1, 1, 1, 0, 2, 0, 4'h0);
    vecs[15] = mk(0, 4'h4, 4'h4, 1, 1, 0, 0, 2, 0, 4'h0);
    vecs[16] = mk(0, 4'h0, 4'h4, 1, 1, 0, 0, 2, 0, 4'h0);
    vecs[17] = mk(0, 4'h0, 4'h4, 1, 1, 0, 0, 2, 0, 4'h0);

    for (int k = 0; k < 18; k++) begin
      RST = vecs[k].rst;
      IRQ_IN = vecs[k].irq;
      IRQ_EN = vecs[k].en;
      CSR_MSTATUS = vecs[k].mie;
      BOUNDARY = vecs[k].bnd;
      CSR_MRET = vecs[k].mret;
      tick();
      chk_all($sformatf("vec%0d", k), vecs[k].taken, vecs[k].id,
              vecs[k].svc, vecs[k].pend);
    end

    // priority: sources 3 and 1 together, 1 first, 3 after MRET
    do_reset();
    IRQ_EN = 4'hF;
    CSR_MSTATUS = 1'b1;
    BOUNDARY = 1'b1;
    IRQ_IN = 4'hA;
    tick(); tick(); tick();
    chk_all("pri.pend", 0, 0, 0, 4'hA);
    tick();
    chk_all("pri.take1", 1, 1, 1, 4'hA);
    CSR_MSTATUS = 1'b0;
    tick();
    chk_all("pri.svc1", 0, 1, 1, 4'h8);
    tick();
    chk_all("pri.hold", 0, 1, 1, 4'h8);
    CSR_MRET = 1'b1;
    tick();
    chk_all("pri.mret", 0, 1, 0, 4'h8);
    CSR_MRET = 1'b0;
    CSR_MSTATUS = 1'b1;
    tick();
    chk_all("pri.take2", 1, 3, 1, 4'h8);
    tick();
    chk_all("pri.svc2", 0, 3, 1, 4'h0);
    CSR_MRET = 1'b1;
    tick();
    CSR_MRET = 1'b0;
    IRQ_IN = 4'h0;

    // gating: MIE off, then BOUNDARY off, then allowed
    do_reset();
    IRQ_EN = 4'hF;
    CSR_MSTATUS = 1'b0;
    BOUNDARY = 1'b1;
    takes = 0;
    for (int p = 0; p < 3; p++) begin
      IRQ_IN = 4'h1;
      tick();
      takes += int'(INT_TAKEN);
      IRQ_IN = 4'h0;
      tick();
      takes += int'(INT_TAKEN);
      tick();
      takes += int'(INT_TAKEN);
    end
    tick(); tick();
    takes += int'(INT_TAKEN);
    check("gate.mie_takes", 32'(takes), 32'd0);
    check("gate.pend", 32'(PENDING), 32'h1);
    CSR_MSTATUS = 1'b1;
    BOUNDARY = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      takes += int'(INT_TAKEN) + int'(IN_SERVICE);
    end
    check("gate.bnd_takes", 32'(takes), 32'd0);
    BOUNDARY = 1'b1;
    tick();
    chk_all("gate.take", 1, 0, 1, 4'h1);
    for (int c = 0; c < 4; c++) begin
      tick();
      takes += int'(INT_TAKEN);
    end
    check("gate.one_take", 32'(takes), 32'd0);
    check("gate.pend_clr", 32'(PENDING), 32'h0);

    // no nesting while in service; MRET during TAKE and IDLE ignored
    IRQ_IN = 4'h1;
    tick(); tick(); tick();
    chk_all("nest.pend", 0, 0, 1, 4'h1);
    tick(); tick();
    chk_all("nest.wait", 0, 0, 1, 4'h1);
    CSR_MRET = 1'b1;
    tick();
    chk_all("nest.mret", 0, 0, 0, 4'h1);
    tick();
    chk_all("nest.take_mret", 1, 0, 1, 4'h1);
    tick();
    chk_all("nest.mret_in_take", 0, 0, 1, 4'h0);
    CSR_MRET = 1'b0;
    tick();
    chk_all("nest.svc", 0, 0, 1, 4'h0);
    CSR_MRET = 1'b1;
    tick();
    chk_all("nest.idle", 0, 0, 0, 4'h0);
    tick();
    chk_all("nest.stray", 0, 0, 0, 4'h0);
    CSR_MRET = 1'b0;
    tick();
    chk_all("nest.idle2", 0, 0, 0, 4'h0);

    // reset mid-service, held lines re-detected afterward
    do_reset();
    IRQ_EN = 4'hF;
    CSR_MSTATUS = 1'b1;
    BOUNDARY = 1'b1;
    IRQ_IN = 4'h1;
    for (int c = 0; c < 5; c++) tick();
    chk_all("rst.svc", 0, 0, 1, 4'h0);
    IRQ_IN = 4'h3;
    tick(); tick(); tick();
    chk_all("rst.pend", 0, 0, 1, 4'h2);
    RST = 1'b1;
    tick();
    chk_all("rst.cleared", 0, 0, 0, 4'h0);
    RST = 1'b0;
    CSR_MSTATUS = 1'b0;
    tick(); tick();
    check("rst.early", 32'(PENDING), 32'h0);
    tick();
    check("rst.refire", 32'(PENDING), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
